// File: rtl/magnetron_pkg.sv
// Shared state type and encoding constants for the magnetron controller.
package magnetron_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COOK  = ST_COOK,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/magnetron_if.sv
// Operator/timer requests in, magnetron drive and status out.
interface magnetron_if #(
    parameter int PWR_W = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             door_closed;
    logic             timer_done;
    logic [PWR_W-1:0] power_lvl;
    logic             mag_on;
    logic [1:0]       state;
    logic             done;

    modport ctrl (
        input  start, stop, clear, door_closed, timer_done, power_lvl,
        output mag_on, state, done
    );

    modport host (
        output start, stop, clear, door_closed, timer_done, power_lvl,
        input  mag_on, state, done
    );
endinterface

// File: rtl/mag_pwm.sv
// Power-level PWM: latches the requested duty on load and gates the drive
// by comparing a free-running window counter against it.
module mag_pwm #(
    parameter int PWR_W   = 4,
    parameter int FULL_ON = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [PWR_W-1:0] lvl_in,
    output logic             on
);

    logic [PWR_W-1:0] pwm_cnt;
    logic [PWR_W-1:0] lvl_q;
    logic             full_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            lvl_q   <= '0;
        end else if (load) begin
            pwm_cnt <= '0;
            lvl_q   <= lvl_in;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Without the all-ones override the top level would still idle one cycle per window.
    assign full_on = (FULL_ON != 0) && (&lvl_q);
    assign on      = en && ((pwm_cnt < lvl_q) || full_on);

endmodule

// File: rtl/magnetron_ctrl.sv
// Microwave cook sequencer: IDLE/COOK/PAUSE/DONE with door interlock and
// PWM-regulated magnetron drive decoded purely from registered state.
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter int PWR_W   = 4,
    parameter int FULL_ON = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    magnetron_if.ctrl    bus
);

    state_t state_q;
    state_t state_n;
    logic   kill;
    logic   can_start;
    logic   pwm_load;
    logic   pwm_en;

    assign kill      = bus.clear || bus.stop;
    assign can_start = bus.start && bus.door_closed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (!kill && can_start) state_n = COOK;
            end
            COOK: begin
                if (kill)                 state_n = IDLE;
                else if (!bus.door_closed) state_n = PAUSE;
                else if (bus.timer_done)  state_n = DONE;
            end
            PAUSE: begin
                if (kill)           state_n = IDLE;
                else if (can_start) state_n = COOK;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Every entry into COOK (fresh start or resume) restarts the PWM window.
    assign pwm_load = (state_n == COOK) && (state_q != COOK);
    assign pwm_en   = (state_q == COOK);

    mag_pwm #(
        .PWR_W   (PWR_W),
        .FULL_ON (FULL_ON)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pwm_en),
        .load   (pwm_load),
        .lvl_in (bus.power_lvl),
        .on     (bus.mag_on)
    );

    assign bus.state = state_q;
    assign bus.done  = (state_q == DONE);

endmodule

// File: doc/magnetron_ctrl.md
MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

Interface
REQ-001 SHALL have parameter PWR_W, default 4: power-level width; PWM window = 2**PWR_W cycles.
REQ-002 SHALL have parameter FULL_ON, default 1: when 1, power_lvl all-ones gives continuous mag_on.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  start/resume request, active-high, level-sampled each clk.
REQ-006 SHALL have port stop  input  1  stop request, active-high.
REQ-007 SHALL have port clear  input  1  clear request, active-high.
REQ-008 SHALL have port door_closed  input  1  door interlock, 1 = closed.
REQ-009 SHALL have port timer_done  input  1  cook timer expired, active-high.
REQ-010 SHALL have port power_lvl  input  PWR_W  requested duty, in on-cycles per window.
REQ-011 SHALL have port mag_on  output  1  magnetron drive.
REQ-012 SHALL have port state  output  2  current state: IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL be a registered FSM with states IDLE, COOK, PAUSE and DONE; the state output SHALL equal the state register.
REQ-015 Input priority in every state SHALL be: clear > stop > door open > timer_done > start.
REQ-016 IDLE: start & door_closed -> COOK. Otherwise stay.
REQ-017 COOK: clear|stop -> IDLE; !door_closed -> PAUSE; timer_done -> DONE; else stay.
REQ-018 PAUSE: clear|stop -> IDLE; start & door_closed -> COOK; timer_done ignored; else stay.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; done = 1 only in DONE.
REQ-020 On every transition into COOK: latch power_lvl into lvl_q and reset pwm_cnt to 0. Changes to power_lvl while in COOK SHALL be ignored.
REQ-021 pwm_cnt: PWR_W bits; increments only in COOK; wraps from 2**PWR_W-1 to 0; holds in PAUSE.
REQ-022 mag_on = (state==COOK) & ((pwm_cnt < lvl_q) | (FULL_ON & lvl_q==all-ones)).
REQ-023 mag_on SHALL decode registered signals only; there SHALL be no combinational path from any input to mag_on.
REQ-024 Latency: when an input event is sampled at edge k, the new state and mag_on SHALL be valid after edge k.
REQ-025 Door open while in COOK SHALL drop mag_on within one clk edge.
REQ-026 mag_on SHALL never be 1 while door_closed was 0 at the preceding edge.
REQ-027 lvl_q = 0 SHALL keep mag_on = 0 for the whole of COOK, while COOK remains otherwise functional.
REQ-028 start while in COOK SHALL have no effect; the PWM phase SHALL NOT restart.
REQ-029 Simultaneous start & stop in IDLE SHALL keep the FSM in IDLE.

Reset
REQ-030 While rst_n = 0: state = IDLE, pwm_cnt = 0, lvl_q = 0, mag_on = 0, done = 0, applied asynchronously.
REQ-031 Reset asserted mid-COOK SHALL drop mag_on immediately, without waiting for clk.
REQ-032 Deassertion of rst_n SHALL be treated as synchronous to clk; the first transition SHALL occur at the first edge with rst_n = 1.

Structure
REQ-033 Package magnetron_pkg SHALL hold the state typedef (2-bit enum IDLE/COOK/PAUSE/DONE) and state encoding constants.
REQ-034 Sub-module mag_pwm SHALL contain pwm_cnt, lvl_q and the compare; ports: clk, rst_n, en, load, lvl_in, on.
REQ-035 The FSM SHALL reside in magnetron_ctrl; no latches; all flops SHALL share clk/rst_n.

Verification (PWR_W=4, FULL_ON=1)
REQ-036 door_closed=1, power_lvl=4, start for 1 cycle -> COOK; mag_on high 4 cycles, low 12 cycles, repeating.
REQ-037 In COOK, door_closed->0 at edge k -> mag_on=0 and state=PAUSE after k; start with door_closed=0 -> stays PAUSE; close door and start -> COOK, with pwm_cnt restarting at 0.
REQ-038 In COOK, timer_done=1 -> DONE for 1 cycle with done=1 and mag_on=0, then IDLE.
REQ-039 In COOK, stop=1 and timer_done=1 in the same cycle -> IDLE, done never asserts.
REQ-040 power_lvl=15 -> mag_on continuously 1 for 40 cycles; power_lvl=0 -> mag_on 0 while state=COOK; power_lvl changed mid-COOK -> duty unchanged.
REQ-041 rst_n pulsed low mid-COOK between clk edges -> mag_on=0 and state=IDLE immediately; no transition until start.
